// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: registers commands onto the ALU valid_in interface, tracks the
// in-flight issues, buffers each response in a result FIFO and owns the carry flag.
module alu_cmd_issuer #(
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_ctl,
  input  logic       cmd_use_cf,
  input  logic       cf_clr,
  output logic       valid_in,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [3:0] ctl,
  input  logic       valid_out,
  input  logic [3:0] alu,
  input  logic       carry,
  input  logic       zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err,
  output logic       cf,
  output logic       proto_err
);

  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + ALU_LAT + 2) + 1;

  logic [ALU_LAT:0] r_track;
  logic [ALU_LAT:0] r_drop;
  logic [6:0]       r_mem [RES_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_inflight;
  logic             w_issue;
  logic             w_expect;
  logic             w_pop;
  logic [6:0]       w_entry;
  logic [6:0]       w_head;

  // Number of issues whose response has not been captured yet
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= ALU_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_track[i]);
    end
  end

  // Credit check plus carry hazard: a carry-using op waits until the pipe is empty
  always_comb begin
    cmd_ready = 1'b0;
    if (reset) begin
      cmd_ready = 1'b0;
    end else if ((r_count + w_inflight) >= CW'(RES_DEPTH)) begin
      cmd_ready = 1'b0;
    end else if (cmd_use_cf && (w_inflight != '0)) begin
      cmd_ready = 1'b0;
    end else begin
      cmd_ready = 1'b1;
    end
  end

  assign w_issue   = cmd_valid && cmd_ready;
  assign w_expect  = r_track[ALU_LAT];
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;
  assign w_entry   = valid_out ? {alu, carry, zero, 1'b0} : 7'b000_0001;
  assign w_head    = res_valid ? r_mem[r_rd_ptr] : 7'b000_0000;
  assign {res_data, res_carry, res_zero, res_err} = w_head;

  // Issue registers, response tracker, carry flag and protocol error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_in  <= 1'b0;
      a         <= 4'd0;
      b         <= 4'd0;
      cin       <= 1'b0;
      ctl       <= 4'd0;
      cf        <= 1'b0;
      proto_err <= 1'b0;
      r_track   <= '0;
      r_drop    <= '1;
    end else begin
      valid_in <= w_issue;
      if (w_issue) begin
        a   <= cmd_a;
        b   <= cmd_b;
        ctl <= cmd_ctl;
        cin <= cmd_use_cf & cf;
      end
      r_track <= {r_track[ALU_LAT-1:0], w_issue};
      // Responses to ops dropped by reset may still trickle in for a few cycles
      r_drop  <= {1'b0, r_drop[ALU_LAT:1]};
      if (cf_clr) begin
        cf <= 1'b0;
      end else if (w_expect && valid_out) begin
        cf <= carry;
      end else begin
        cf <= cf;
      end
      if (valid_out && !w_expect && (r_drop == '0)) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Result FIFO; the issue credit keeps it from ever overflowing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_expect) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      case ({w_expect, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: a small behavioural ALU, a queue-based
// reference model checked every cycle, directed scenarios and a random phase.
module tb_alu_cmd_issuer;

  localparam int RES_DEPTH = 4;
  localparam int ALU_LAT   = 1;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SEL  = 4'd7;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, cmd_use_cf, cf_clr;
  logic [3:0] cmd_a, cmd_b, cmd_ctl;
  logic       valid_in, cin, valid_out, carry, zero;
  logic [3:0] a, b, ctl, alu;
  logic       res_valid, res_ready, res_carry, res_zero, res_err, cf, proto_err;
  logic [3:0] res_data;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.RES_DEPTH(RES_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl), .cmd_use_cf(cmd_use_cf),
    .cf_clr(cf_clr), .valid_in(valid_in), .a(a), .b(b), .cin(cin), .ctl(ctl),
    .valid_out(valid_out), .alu(alu), .carry(carry), .zero(zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err),
    .cf(cf), .proto_err(proto_err)
  );

  // Reference ALU: returns {legal, result[3:0], carry, zero}
  function automatic logic [6:0] alu_ref(input logic [3:0] op, input logic [3:0] x,
                                         input logic [3:0] y, input logic ci);
    logic [4:0] s;
    logic       ok;
    ok = 1'b1;
    s  = 5'd0;
    case (op)
      4'd0:    s = {1'b0, x} + {1'b0, y};
      4'd1:    s = {1'b0, x} + {1'b0, y} + {4'd0, ci};
      4'd2:    s = {1'b0, x} - {1'b0, y};
      4'd3:    s = {1'b0, x} - {1'b0, y} - {4'd0, ci};
      4'd4:    s = {1'b0, x & y};
      4'd5:    s = {1'b0, x | y};
      4'd6:    s = {1'b0, x ^ y};
      4'd7:    s = {1'b0, y};
      default: ok = 1'b0;
    endcase
    return {ok, s[3:0], s[4], (s[3:0] == 4'd0)};
  endfunction

  // Behavioural ALU with one register stage; force_vo injects a stray valid_out
  logic       force_vo, alu_vo_r, alu_c_r, alu_z_r;
  logic [3:0] alu_r;
  logic [6:0] alu_calc;
  assign alu_calc  = alu_ref(ctl, a, b, cin);
  assign valid_out = alu_vo_r | force_vo;
  assign alu       = alu_r;
  assign carry     = alu_c_r;
  assign zero      = alu_z_r;

  always @(posedge clk) begin
    if (reset) begin
      alu_vo_r <= 1'b0; alu_r <= 4'd0; alu_c_r <= 1'b0; alu_z_r <= 1'b0;
    end else begin
      alu_vo_r <= valid_in & alu_calc[6];
      alu_r    <= alu_calc[5:2];
      alu_c_r  <= alu_calc[1];
      alu_z_r  <= alu_calc[0];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model: accepted ops awaiting their response, then buffered results
  typedef struct {
    int         due;
    logic       legal;
    logic [3:0] res;
    logic       c;
    logic       z;
  } pend_t;

  pend_t      pend_q[$];
  logic [6:0] out_q[$];
  logic       cf_m = 1'b0, proto_m = 1'b0, exp_vin = 1'b0, exp_cin = 1'b0;
  logic [3:0] exp_a = 4'd0, exp_b = 4'd0, exp_ctl = 4'd0;
  logic       exp_ready_m, cf_old_m, cap_m;
  logic [6:0] head_m, ref_m;
  pend_t      pe_m;
  int         cyc = 0;
  bit         run = 1'b0;

  // Compare DUT against the model, then advance the model across the next edge
  always @(negedge clk) begin
    if (run) begin
      exp_ready_m = !reset && ((pend_q.size() + out_q.size()) < RES_DEPTH)
                    && !(cmd_use_cf && (pend_q.size() != 0));
      head_m = (out_q.size() != 0) ? out_q[0] : 7'd0;
      chk("cmd_ready", 8'(cmd_ready), 8'(exp_ready_m));
      chk("res_valid", 8'(res_valid), 8'(out_q.size() != 0));
      chk("res_data",  8'(res_data),  8'(head_m[6:3]));
      chk("res_carry", 8'(res_carry), 8'(head_m[2]));
      chk("res_zero",  8'(res_zero),  8'(head_m[1]));
      chk("res_err",   8'(res_err),   8'(head_m[0]));
      chk("cf",        8'(cf),        8'(cf_m));
      chk("proto_err", 8'(proto_err), 8'(proto_m));
      chk("valid_in",  8'(valid_in),  8'(exp_vin));
      if (exp_vin) begin
        chk("alu_a",   8'(a),   8'(exp_a));
        chk("alu_b",   8'(b),   8'(exp_b));
        chk("alu_ctl", 8'(ctl), 8'(exp_ctl));
        chk("alu_cin", 8'(cin), 8'(exp_cin));
      end
      if (reset) begin
        pend_q.delete();
        out_q.delete();
        cf_m    = 1'b0;
        proto_m = 1'b0;
        exp_vin = 1'b0;
      end else begin
        cf_old_m = cf_m;
        cap_m    = 1'b0;
        if ((out_q.size() != 0) && res_ready) void'(out_q.pop_front());
        if ((pend_q.size() != 0) && (pend_q[0].due == cyc)) begin
          pe_m  = pend_q.pop_front();
          cap_m = 1'b1;
          if (pe_m.legal) begin
            out_q.push_back({pe_m.res, pe_m.c, pe_m.z, 1'b0});
            cf_m = pe_m.c;
          end else begin
            out_q.push_back(7'b000_0001);
          end
        end
        if (cf_clr) cf_m = 1'b0;
        if (force_vo && !cap_m) proto_m = 1'b1;
        exp_vin = cmd_valid && exp_ready_m;
        if (exp_vin) begin
          exp_a   = cmd_a;
          exp_b   = cmd_b;
          exp_ctl = cmd_ctl;
          exp_cin = cmd_use_cf ? cf_old_m : 1'b0;
          ref_m   = alu_ref(cmd_ctl, cmd_a, cmd_b, exp_cin);
          pend_q.push_back('{cyc + ALU_LAT + 1, ref_m[6], ref_m[5:2], ref_m[1], ref_m[0]});
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until it is accepted; returns just after that edge
  task automatic issue(input logic [3:0] op, input logic [3:0] xa, input logic [3:0] xb,
                       input logic uc);
    logic acc;
    acc = 1'b0;
    cmd_ctl = op; cmd_a = xa; cmd_b = xb; cmd_use_cf = uc; cmd_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      if (acc) break;
    end
    cmd_valid  = 1'b0;
    cmd_use_cf = 1'b0;
    if (!acc) timeout_fail("issue");
  endtask

  // Wait for the FIFO head, compare it with literal values, then pop it
  task automatic get_res(input string name, input logic [3:0] d, input logic c,
                         input logic z, input logic e);
    logic       got;
    logic [6:0] f;
    got = 1'b0;
    f   = 7'd0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      got = res_valid;
      f   = {res_data, res_carry, res_zero, res_err};
      step();
      if (got) break;
    end
    if (!got) begin
      timeout_fail(name);
    end else begin
      chk({name, "_data"}, 8'(f[6:3]), 8'(d));
      chk({name, "_carry"}, 8'(f[2]), 8'(c));
      chk({name, "_zero"}, 8'(f[1]), 8'(z));
      chk({name, "_err"}, 8'(f[0]), 8'(e));
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_ctl = 4'd0;
    cmd_use_cf = 1'b0; cf_clr = 1'b0; res_ready = 1'b0; force_vo = 1'b0;
    step();
    run = 1'b1;
    step();
    reset = 1'b0;
    step();

    // 1: plain ADD, single valid_in pulse
    issue(OP_ADD, 4'd3, 4'd4, 1'b0);
    @(negedge clk);
    chk("t1_vin_pulse", 8'(valid_in), 8'd1);
    chk("t1_a", 8'(a), 8'd3);
    chk("t1_b", 8'(b), 8'd4);
    step();
    @(negedge clk);
    chk("t1_vin_low", 8'(valid_in), 8'd0);
    step();
    get_res("t1", 4'd7, 1'b0, 1'b0, 1'b0);
    chk("t1_cf", 8'(cf), 8'd0);

    // 2: carry hazard stall, ADD_c sees the previous carry
    issue(OP_ADD, 4'hF, 4'h1, 1'b0);
    cmd_ctl = OP_ADDC; cmd_a = 4'd0; cmd_b = 4'd0; cmd_use_cf = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    chk("t2_stall", 8'(cmd_ready), 8'd0);
    step();
    issue(OP_ADDC, 4'd0, 4'd0, 1'b1);
    get_res("t2a", 4'd0, 1'b1, 1'b1, 1'b0);
    get_res("t2b", 4'd1, 1'b0, 1'b0, 1'b0);
    chk("t2_cf", 8'(cf), 8'd0);

    // 3: credit limit with the consumer stalled
    for (int i = 0; i < 4; i++) issue(OP_ADD, 4'(i), 4'd1, 1'b0);
    repeat (4) step();
    @(negedge clk);
    chk("t3_full", 8'(cmd_ready), 8'd0);
    step();
    get_res("t3_0", 4'd1, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 4'd4, 4'd1, 1'b0);
    for (int i = 1; i < 5; i++) get_res("t3_n", 4'(i + 1), 1'b0, 1'b0, 1'b0);

    // 4: illegal opcode yields an error entry and keeps cf
    issue(OP_ADD, 4'hF, 4'h1, 1'b0);
    get_res("t4_set", 4'd0, 1'b1, 1'b1, 1'b0);
    chk("t4_cf_set", 8'(cf), 8'd1);
    issue(4'hF, 4'd2, 4'd3, 1'b0);
    get_res("t4_ill", 4'd0, 1'b0, 1'b0, 1'b1);
    chk("t4_cf_kept", 8'(cf), 8'd1);
    issue(OP_SEL, 4'd0, 4'd9, 1'b0);
    get_res("t4_sel", 4'd9, 1'b0, 1'b0, 1'b0);

    // 5: reset the cycle after valid_in drops the op
    issue(OP_ADD, 4'hF, 4'h1, 1'b0);
    get_res("t5_pre", 4'd0, 1'b1, 1'b1, 1'b0);
    issue(OP_ADD, 4'd1, 4'd1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("t5_empty", 8'(res_valid), 8'd0);
    chk("t5_cf", 8'(cf), 8'd0);
    chk("t5_proto", 8'(proto_err), 8'd0);

    // 6: stray valid_out is sticky; cf_clr beats a capture
    step();
    force_vo = 1'b1;
    step();
    force_vo = 1'b0;
    step();
    chk("t6_proto_set", 8'(proto_err), 8'd1);
    issue(OP_ADD, 4'hF, 4'h1, 1'b0);
    step();
    cf_clr = 1'b1;
    step();
    cf_clr = 1'b0;
    chk("t6_cf_clr", 8'(cf), 8'd0);
    get_res("t6", 4'd0, 1'b1, 1'b1, 1'b0);
    chk("t6_proto_sticky", 8'(proto_err), 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_proto_rst", 8'(proto_err), 8'd0);
    step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      cmd_valid  = ($urandom_range(0, 9) < 7);
      cmd_a      = 4'($urandom);
      cmd_b      = 4'($urandom);
      cmd_ctl    = 4'($urandom_range(0, 9));
      cmd_use_cf = ($urandom_range(0, 2) == 0);
      cf_clr     = ($urandom_range(0, 15) == 0);
      res_ready  = ($urandom_range(0, 1) == 1);
      step();
    end
    reset = 1'b0; cmd_valid = 1'b0; cf_clr = 1'b0; res_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
